// File: rtl/cpu_pkg.sv
// Shared WISC CPU types: opcodes, branch condition codes and the IF/ID register payload.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OPC_W  = 4;
  localparam int unsigned CC_W   = 3;
  localparam int unsigned FLAG_W = 3;
  localparam int unsigned PRED_W = 2;
  localparam int unsigned OFF_W  = 9;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_B  = 4'hC,
    OP_BR = 4'hD
  } opcode_e;

  typedef enum logic [CC_W-1:0] {
    CC_NE     = 3'b000,
    CC_EQ     = 3'b001,
    CC_GT     = 3'b010,
    CC_LT     = 3'b011,
    CC_GTE    = 3'b100,
    CC_LTE    = 3'b101,
    CC_OVFL   = 3'b110,
    CC_UNCOND = 3'b111
  } cc_e;

  // Only the predictor-index bits of the fetch PC are kept in IF/ID.
  typedef struct packed {
    logic [IDX_W-1:0]  pc_curr;
    logic [DATA_W-1:0] pc_next;
    logic [DATA_W-1:0] inst;
    logic [PRED_W-1:0] prediction;
    logic [DATA_W-1:0] predicted_target;
    logic              valid;
  } if_id_reg_t;

  // Sign-extended B offset, already scaled to a byte displacement.
  function automatic logic [DATA_W-1:0] br_offset(input logic [OFF_W-1:0] off9);
    return {{(DATA_W-OFF_W-1){off9[OFF_W-1]}}, off9, 1'b0};
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: (ccc, {Z,V,N}) -> cond.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [CC_W-1:0]   ccc,
  input  logic [FLAG_W-1:0] flags,
  output logic              cond
);

  logic z, v, n;

  assign z = flags[2];
  assign v = flags[1];
  assign n = flags[0];

  always_comb begin
    cond = 1'b0;
    unique case (cc_e'(ccc))
      CC_NE:     cond = !z;
      CC_EQ:     cond = z;
      CC_GT:     cond = !z && !n;
      CC_LT:     cond = n;
      CC_GTE:    cond = z || !n;
      CC_LTE:    cond = n || z;
      CC_OVFL:   cond = v;
      CC_UNCOND: cond = 1'b1;
      default:   cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/if_id_branch_resolve.sv
// IF/ID pipeline register with zero-cycle decode-stage branch resolution and squash.
// Optional BRANCH_STATS_EN adds saturating branch / mispredict counters.
module if_id_branch_resolve
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [DATA_W-1:0] PC_curr,
  input  logic [DATA_W-1:0] PC_next,
  input  logic [DATA_W-1:0] PC_inst,
  input  logic [PRED_W-1:0] prediction,
  input  logic [DATA_W-1:0] predicted_target,
  input  logic [FLAG_W-1:0] flags,
  input  logic [DATA_W-1:0] br_reg_data,
  output logic [DATA_W-1:0] actual_target,
  output logic              actual_taken,
  output logic              wen_BHT,
  output logic              wen_BTB,
  output logic              update_PC,
  output logic [IDX_W-1:0]  IF_ID_PC_curr,
  output logic [PRED_W-1:0] IF_ID_prediction,
  output logic [DATA_W-1:0] IF_ID_PC_next,
  output logic [DATA_W-1:0] IF_ID_inst,
  output logic              IF_ID_valid
`ifdef BRANCH_STATS_EN
  ,
  output logic [DATA_W-1:0] br_count,
  output logic [DATA_W-1:0] mispred_count
`endif
);

  if_id_reg_t        if_id_q;
  logic [OPC_W-1:0]  opcode;
  logic              is_b;
  logic              is_brr;
  logic              is_br;
  logic              cond;
  logic              pred_taken;
  logic              tgt_diff;
  logic              mispredict;
  logic [DATA_W-1:0] br_target;
  logic              unused_pc_hi;

  assign unused_pc_hi = ^PC_curr[DATA_W-1:IDX_W];

  // Flush outranks stall so the wrong-path fetch is always squashed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_q <= '0;
    end else if (update_PC) begin
      if_id_q.valid <= 1'b0;
      if_id_q.inst  <= '0;
    end else if (!stall) begin
      if_id_q.pc_curr          <= PC_curr[IDX_W-1:0];
      if_id_q.pc_next          <= PC_next;
      if_id_q.inst             <= PC_inst;
      if_id_q.prediction       <= prediction;
      if_id_q.predicted_target <= predicted_target;
      if_id_q.valid            <= 1'b1;
    end
  end

  assign opcode = if_id_q.inst[DATA_W-1:DATA_W-OPC_W];
  assign is_b   = (opcode == OP_B);
  assign is_brr = (opcode == OP_BR);

  branch_cond_eval u_cond (
    .ccc   (if_id_q.inst[11:9]),
    .flags (flags),
    .cond  (cond)
  );

  assign br_target = is_brr ? br_reg_data
                            : DATA_W'(if_id_q.pc_next + br_offset(if_id_q.inst[OFF_W-1:0]));

  // A stalled slot resolves nothing; it resolves once when the stall drops.
  assign is_br      = if_id_q.valid && (is_b || is_brr) && !stall;
  assign pred_taken = if_id_q.prediction[PRED_W-1];
  assign tgt_diff   = (br_target != if_id_q.predicted_target);

  assign actual_taken  = is_br && cond;
  assign actual_target = actual_taken ? br_target : if_id_q.pc_next;
  assign mispredict    = (pred_taken != actual_taken) || (pred_taken && actual_taken && tgt_diff);
  assign update_PC     = is_br && mispredict;
  assign wen_BHT       = is_br;
  assign wen_BTB       = is_br && actual_taken && tgt_diff;

  assign IF_ID_PC_curr    = if_id_q.pc_curr;
  assign IF_ID_prediction = if_id_q.prediction;
  assign IF_ID_PC_next    = if_id_q.pc_next;
  assign IF_ID_inst       = if_id_q.inst;
  assign IF_ID_valid      = if_id_q.valid;

`ifdef BRANCH_STATS_EN
  localparam logic [DATA_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (wen_BHT && (br_count != CNT_MAX)) begin
        br_count <= br_count + DATA_W'(1);
      end
      if (update_PC && (mispred_count != CNT_MAX)) begin
        mispred_count <= mispred_count + DATA_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_branch_resolve.sv
// Directed scoreboard bench for the IF/ID register and decode-stage branch resolver.
module tb_if_id_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [15:0] PC_curr, PC_next, PC_inst, predicted_target, br_reg_data;
  logic [1:0]  prediction;
  logic [2:0]  flags;
  logic [15:0] actual_target;
  logic        actual_taken, wen_BHT, wen_BTB, update_PC;
  logic [3:0]  IF_ID_PC_curr;
  logic [1:0]  IF_ID_prediction;
  logic [15:0] IF_ID_PC_next, IF_ID_inst;
  logic        IF_ID_valid;
`ifdef BRANCH_STATS_EN
  logic [15:0] br_count, mispred_count;
`endif

  if_id_branch_resolve dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .PC_curr          (PC_curr),
    .PC_next          (PC_next),
    .PC_inst          (PC_inst),
    .prediction       (prediction),
    .predicted_target (predicted_target),
    .flags            (flags),
    .br_reg_data      (br_reg_data),
    .actual_target    (actual_target),
    .actual_taken     (actual_taken),
    .wen_BHT          (wen_BHT),
    .wen_BTB          (wen_BTB),
    .update_PC        (update_PC),
    .IF_ID_PC_curr    (IF_ID_PC_curr),
    .IF_ID_prediction (IF_ID_prediction),
    .IF_ID_PC_next    (IF_ID_PC_next),
    .IF_ID_inst       (IF_ID_inst),
    .IF_ID_valid      (IF_ID_valid)
`ifdef BRANCH_STATS_EN
    ,
    .br_count         (br_count),
    .mispred_count    (mispred_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        full;
    logic        taken;
    logic [15:0] target;
    logic        upd;
    logic        bht;
    logic        btb;
    logic        valid;
    logic [15:0] inst;
    logic [3:0]  pc_idx;
    logic [15:0] pc_next;
    logic [1:0]  pred;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_br  = 0;
  int   exp_mis = 0;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] pc, input logic [15:0] inst,
                       input logic [1:0] pred, input logic [15:0] ptgt);
    PC_curr          = pc;
    PC_next          = pc + 16'd2;
    PC_inst          = inst;
    prediction       = pred;
    predicted_target = ptgt;
  endtask

  task automatic push(input logic full, input logic taken, input logic [15:0] target,
                      input logic upd, input logic bht, input logic btb, input logic valid,
                      input logic [15:0] inst, input logic [3:0] pc_idx,
                      input logic [15:0] pc_next, input logic [1:0] pred);
    sb_q.push_back('{full, taken, target, upd, bht, btb, valid, inst, pc_idx, pc_next, pred});
  endtask

  task automatic chk1(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      exp_br  += int'(e.bht);
      exp_mis += int'(e.upd);
      chk1({tag, ".valid"}, 16'(IF_ID_valid), 16'(e.valid));
      chk1({tag, ".inst"}, IF_ID_inst, e.inst);
      chk1({tag, ".taken"}, 16'(actual_taken), 16'(e.taken));
      chk1({tag, ".update_PC"}, 16'(update_PC), 16'(e.upd));
      chk1({tag, ".wen_BHT"}, 16'(wen_BHT), 16'(e.bht));
      chk1({tag, ".wen_BTB"}, 16'(wen_BTB), 16'(e.btb));
      if (e.full) begin
        chk1({tag, ".target"}, actual_target, e.target);
        chk1({tag, ".pc_idx"}, 16'(IF_ID_PC_curr), 16'(e.pc_idx));
        chk1({tag, ".pc_next"}, IF_ID_PC_next, e.pc_next);
        chk1({tag, ".pred"}, 16'(IF_ID_prediction), 16'(e.pred));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flags = 3'b000;
    br_reg_data = 16'h0000;
    fetch(16'h0000, 16'h0000, 2'b00, 16'h0000);

    repeat (2) @(posedge clk);
    #1;
    push(1, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 4'h0, 16'h0000, 2'b00);
    check_out("reset");
    rst_n = 1'b1;

    // B NE at 0x0010 predicted not-taken, Z=1: correct fall-through
    fetch(16'h0010, 16'hC004, 2'b00, 16'h0000);
    flags = 3'b100;
    cycle(); #1;
    push(1, 0, 16'h0012, 0, 1, 0, 1, 16'hC004, 4'h0, 16'h0012, 2'b00);
    check_out("fallthru");

    // Same branch, Z=0, predicted not-taken: taken mispredict
    fetch(16'h0010, 16'hC004, 2'b01, 16'h0000);
    cycle();
    flags = 3'b000;
    #1;
    push(1, 1, 16'h001A, 1, 1, 1, 1, 16'hC004, 4'h0, 16'h0012, 2'b01);
    check_out("taken_mispred");
    fetch(16'h0012, 16'h1111, 2'b00, 16'h0000);
    cycle(); #1;
    push(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 4'h0, 16'h0000, 2'b00);
    check_out("squash1");

    // Non-branch with a taken prediction: nothing resolves
    fetch(16'h0020, 16'h1234, 2'b11, 16'h0040);
    cycle(); #1;
    push(1, 0, 16'h0022, 0, 0, 0, 1, 16'h1234, 4'h0, 16'h0022, 2'b11);
    check_out("nonbranch");

    // B UNCOND off9=0x100 at 0x0002 wraps to 0xFE04, predicted correctly
    fetch(16'h0002, 16'hCF00, 2'b11, 16'hFE04);
    cycle(); #1;
    push(1, 1, 16'hFE04, 0, 1, 0, 1, 16'hCF00, 4'h2, 16'h0004, 2'b11);
    check_out("off_wrap");

    // BR UNCOND with stale BTB target
    fetch(16'h0030, 16'hDE10, 2'b11, 16'h0200);
    cycle();
    br_reg_data = 16'h0100;
    #1;
    push(1, 1, 16'h0100, 1, 1, 1, 1, 16'hDE10, 4'h0, 16'h0032, 2'b11);
    check_out("br_btb");
    fetch(16'h0032, 16'h2222, 2'b00, 16'h0000);
    cycle(); #1;
    push(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 4'h0, 16'h0000, 2'b00);
    check_out("squash2");

    // B LT predicted taken, N=0: not-taken mispredict redirects to PC+2
    fetch(16'h0050, 16'hC604, 2'b11, 16'h005A);
    flags = 3'b000;
    cycle(); #1;
    push(1, 0, 16'h0052, 1, 1, 0, 1, 16'hC604, 4'h0, 16'h0052, 2'b11);
    check_out("nt_mispred");
    fetch(16'h0052, 16'h3333, 2'b00, 16'h0000);
    cycle(); #1;
    push(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 4'h0, 16'h0000, 2'b00);
    check_out("squash3");

    // B EQ held by stall for 3 edges, then resolves exactly once
    fetch(16'h0040, 16'hC204, 2'b10, 16'h004A);
    flags = 3'b100;
    cycle();
    stall = 1'b1;
    fetch(16'h0099, 16'hFFFF, 2'b01, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      #1;
      push(0, 0, 16'h0000, 0, 0, 0, 1, 16'hC204, 4'h0, 16'h0000, 2'b00);
      check_out("stall_hold");
      chk1("stall_pc_next", IF_ID_PC_next, 16'h0042);
      chk1("stall_pred", 16'(IF_ID_prediction), 16'(2'b10));
      cycle();
    end
    stall = 1'b0;
    fetch(16'h0044, 16'h2000, 2'b00, 16'h0000);
    #1;
    push(1, 1, 16'h004A, 0, 1, 0, 1, 16'hC204, 4'h0, 16'h0042, 2'b10);
    check_out("stall_release");
    cycle(); #1;
    push(1, 0, 16'h0046, 0, 0, 0, 1, 16'h2000, 4'h4, 16'h0046, 2'b00);
    check_out("post_release");

`ifdef BRANCH_STATS_EN
    chk1("br_count", br_count, 16'(exp_br));
    chk1("mispred_count", mispred_count, 16'(exp_mis));
`endif

    // Asynchronous reset mid-operation with a mispredicting branch in ID
    fetch(16'h0010, 16'hC004, 2'b01, 16'h0000);
    flags = 3'b000;
    cycle(); #1;
    chk1("pre_reset_update_PC", 16'(update_PC), 16'h0001);
    rst_n = 1'b0;
    #1;
    push(1, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 4'h0, 16'h0000, 2'b00);
    check_out("async_reset");
    cycle();
    rst_n = 1'b1;
    cycle();

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
